soc_reset_sequencer: RTL and testbench

//  Parametrised multi-channel reset generator for the SoC top. Synchronises an

---
 rtl/soc_reset_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_soc_reset_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// soc_reset_sequencer
//
// Multi-channel reset generator for the SoC top level. An external reset
// button (asynchronous, active-high) is brought into the g_clk domain through
// a flop chain. Software can request a reset of a subset of domains. The
// affected domains are held low for at least HOLD_CYCLES and then released
// one after another, STAGGER_CYCLES apart, lowest index first. The block also
// reports the cause of the most recent reset and a saturating reset count.
//
// Ports
//   g_clk          in   1          system clock
//   g_resetn       in   1          power-on reset, asynchronous, active-low
//   ext_reset      in   1          external reset button, async to g_clk
//   sw_reset_req   in   1          software reset request pulse (g_clk domain)
//   sw_reset_mask  in   CHANNELS   domains hit by sw_reset_req, sampled with it
//   rst_n_out      out  CHANNELS   per-domain reset, active-low, registered
//   seq_busy       out  1          high while holding or releasing domains
//   reset_cause    out  2          00 power-on, 01 external, 10 software
//   reset_count    out  8          resets since power-on, saturating at 255
// -----------------------------------------------------------------------------
module soc_reset_sequencer #(
  parameter int CHANNELS       = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                ext_reset,
  input  logic                sw_reset_req,
  input  logic [CHANNELS-1:0] sw_reset_mask,
  output logic [CHANNELS-1:0] rst_n_out,
  output logic                seq_busy,
  output logic [1:0]          reset_cause,
  output logic [7:0]          reset_count
);

  // Hold and stagger counters share one width, sized for the longer interval.
  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0]    IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [CHANNELS-1:0] ALL_CH    = {CHANNELS{1'b1}};
  localparam logic [CHANNELS-1:0] NO_CH     = {CHANNELS{1'b0}};
  localparam logic [CHANNELS-1:0] CH0_BIT   = CHANNELS'(1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ext_sync_s;

  state_e                 state_r,       state_s;
  logic [CNT_W-1:0]       hold_cnt_r,    hold_cnt_s;
  logic [CNT_W-1:0]       stag_cnt_r,    stag_cnt_s;
  logic [IDX_W-1:0]       idx_r,         idx_s;
  logic [CHANNELS-1:0]    active_mask_r, active_mask_s;
  logic [CHANNELS-1:0]    rst_n_r,       rst_n_s;
  logic                   busy_r,        busy_s;
  logic [1:0]             cause_r,       cause_s;
  logic [7:0]             count_r,       count_s;
  logic [7:0]             count_inc_s;

  // Bring the external button into the g_clk domain; only the last stage is used.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_reset};
    end
  end

  assign ext_sync_s = sync_r[SYNC_STAGES-1];

  // Saturating increment of the reset counter.
  assign count_inc_s = (count_r == 8'hFF) ? count_r : (count_r + 8'd1);

  // Next-state and next-output logic for the hold / release / run sequence.
  always_comb begin
    state_s       = state_r;
    hold_cnt_s    = hold_cnt_r;
    stag_cnt_s    = stag_cnt_r;
    idx_s         = idx_r;
    active_mask_s = active_mask_r;
    rst_n_s       = rst_n_r;
    busy_s        = busy_r;
    cause_s       = cause_r;
    count_s       = count_r;

    case (state_r)
      ST_ASSERT: begin
        // Domains not in the active mask keep whatever value they had.
        rst_n_s    = rst_n_r & ~active_mask_r;
        stag_cnt_s = CNT_ZERO;
        if (ext_sync_s) begin
          // Button still pressed: stretch the hold window.
          hold_cnt_s = CNT_ZERO;
        end else if (hold_cnt_r == HOLD_LAST) begin
          hold_cnt_s = CNT_ZERO;
          rst_n_s[0] = 1'b1;
          idx_s      = IDX_ONE;
          if (CHANNELS == 1) begin
            state_s = ST_RUN;
            busy_s  = 1'b0;
          end else begin
            state_s = ST_RELEASE;
            busy_s  = 1'b1;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (ext_sync_s) begin
          // External reset aborts the release and restarts a full sequence.
          state_s       = ST_ASSERT;
          hold_cnt_s    = CNT_ZERO;
          stag_cnt_s    = CNT_ZERO;
          idx_s         = IDX_ZERO;
          active_mask_s = ALL_CH;
          rst_n_s       = NO_CH;
          busy_s        = 1'b1;
          cause_s       = CAUSE_EXT;
          count_s       = count_inc_s;
        end else if (stag_cnt_r == STAG_LAST) begin
          // Releasing an unmasked domain is harmless: it is already high.
          stag_cnt_s = CNT_ZERO;
          rst_n_s    = rst_n_r | (CH0_BIT << idx_r);
          if (idx_r == IDX_LAST) begin
            state_s = ST_RUN;
            busy_s  = 1'b0;
            idx_s   = IDX_ZERO;
          end else begin
            idx_s   = idx_r + IDX_ONE;
          end
        end else begin
          stag_cnt_s = stag_cnt_r + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (ext_sync_s) begin
          // External reset has priority over a simultaneous software request.
          state_s       = ST_ASSERT;
          hold_cnt_s    = CNT_ZERO;
          stag_cnt_s    = CNT_ZERO;
          idx_s         = IDX_ZERO;
          active_mask_s = ALL_CH;
          rst_n_s       = NO_CH;
          busy_s        = 1'b1;
          cause_s       = CAUSE_EXT;
          count_s       = count_inc_s;
        end else if (sw_reset_req && (sw_reset_mask != NO_CH)) begin
          state_s       = ST_ASSERT;
          hold_cnt_s    = CNT_ZERO;
          stag_cnt_s    = CNT_ZERO;
          idx_s         = IDX_ZERO;
          active_mask_s = sw_reset_mask;
          rst_n_s       = rst_n_r & ~sw_reset_mask;
          busy_s        = 1'b1;
          cause_s       = CAUSE_SW;
          count_s       = count_inc_s;
        end else begin
          // Idle, or a software request with an empty mask: nothing happens.
          state_s = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a full reset of every domain.
        state_s       = ST_ASSERT;
        hold_cnt_s    = CNT_ZERO;
        stag_cnt_s    = CNT_ZERO;
        idx_s         = IDX_ZERO;
        active_mask_s = ALL_CH;
        rst_n_s       = NO_CH;
        busy_s        = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r       <= ST_ASSERT;
      hold_cnt_r    <= CNT_ZERO;
      stag_cnt_r    <= CNT_ZERO;
      idx_r         <= IDX_ZERO;
      active_mask_r <= ALL_CH;
      rst_n_r       <= NO_CH;
      busy_r        <= 1'b1;
      cause_r       <= CAUSE_POR;
      count_r       <= 8'd0;
    end else begin
      state_r       <= state_s;
      hold_cnt_r    <= hold_cnt_s;
      stag_cnt_r    <= stag_cnt_s;
      idx_r         <= idx_s;
      active_mask_r <= active_mask_s;
      rst_n_r       <= rst_n_s;
      busy_r        <= busy_s;
      cause_r       <= cause_s;
      count_r       <= count_s;
    end
  end

  assign rst_n_out   = rst_n_r;
  assign seq_busy    = busy_r;
  assign reset_cause = cause_r;
  assign reset_count = count_r;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_soc_reset_sequencer
//
// Bench for soc_reset_sequencer with default parameters. The reference model
// tracks a reset sequence as a timeline: the edge at which the hold window was
// last (re)started ("anchor"), the set of affected domains, the cause and the
// count. Domain i is high once the edge number reaches
// anchor + HOLD + i*STAG; the sequence is busy until the last domain is out.
// -----------------------------------------------------------------------------
module tb_soc_reset_sequencer;

  localparam int CH   = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int STAG = 8;

  logic          g_clk = 1'b0;
  logic          g_resetn;
  logic          ext_reset;
  logic          sw_reset_req;
  logic [CH-1:0] sw_reset_mask;
  logic [CH-1:0] rst_n_out;
  logic          seq_busy;
  logic [1:0]    reset_cause;
  logic [7:0]    reset_count;

  int n_cmp = 0;
  int n_err = 0;

  soc_reset_sequencer #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .ext_reset(ext_reset),
    .sw_reset_req(sw_reset_req), .sw_reset_mask(sw_reset_mask),
    .rst_n_out(rst_n_out), .seq_busy(seq_busy),
    .reset_cause(reset_cause), .reset_count(reset_count)
  );

  always #5 g_clk = ~g_clk;

  // ---------------- reference model ----------------
  int            m_n;
  int            m_anchor;
  int            m_count;
  logic [CH-1:0] m_mask;
  logic [1:0]    m_cause;
  logic [SYNC-1:0] m_hist;

  function automatic void model_reset();
    m_n      = 0;
    m_anchor = 0;
    m_count  = 0;
    m_mask   = '1;
    m_cause  = 2'b00;
    m_hist   = '0;
  endfunction

  function automatic void model_start(input logic [CH-1:0] mk, input logic [1:0] c);
    m_anchor = m_n;
    m_mask   = mk;
    m_cause  = c;
    if (m_count < 255) m_count = m_count + 1;
  endfunction

  function automatic void model_edge(input bit ext, input bit sw, input logic [CH-1:0] mk);
    bit es;
    es  = m_hist[SYNC-1];
    m_n = m_n + 1;
    if (m_n - 1 < m_anchor + HOLD) begin
      if (es) m_anchor = m_n;
    end else if (m_n - 1 < m_anchor + HOLD + (CH-1)*STAG) begin
      if (es) model_start('1, 2'b01);
    end else begin
      if (es) model_start('1, 2'b01);
      else if (sw && (mk != '0)) model_start(mk, 2'b10);
    end
    m_hist = {m_hist[SYNC-2:0], ext};
  endfunction

  function automatic logic [CH-1:0] m_rst();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++)
      r[i] = m_mask[i] ? ((m_n >= m_anchor + HOLD + i*STAG) ? 1'b1 : 1'b0) : 1'b1;
    return r;
  endfunction

  function automatic bit m_busy();
    return (m_n < m_anchor + HOLD + (CH-1)*STAG);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rst"},   32'(rst_n_out),   32'(m_rst()));
    chk({tag, "_busy"},  32'(seq_busy),    32'(m_busy()));
    chk({tag, "_cause"}, 32'(reset_cause), 32'(m_cause));
    chk({tag, "_count"}, 32'(reset_count), 32'(m_count));
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic cycle(input bit ext, input bit sw, input logic [CH-1:0] mk, input string tag);
    ext_reset     = ext;
    sw_reset_req  = sw;
    sw_reset_mask = mk;
    @(posedge g_clk);
    model_edge(ext, sw, mk);
    @(negedge g_clk);
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int            ncyc;
    bit            ext;
    bit            sw;
    logic [CH-1:0] mask;
    logic [CH-1:0] e_rst;
    bit            e_busy;
    logic [1:0]    e_cause;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t vq[$];

  initial begin
    // POR release at edges 16/24/32
    vq.push_back('{15, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 8'd0});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'b00, 8'd0});
    vq.push_back('{ 7, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'b00, 8'd0});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b00, 8'd0});
    vq.push_back('{ 7, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b00, 8'd0});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 2'b00, 8'd0});
    vq.push_back('{ 3, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 2'b00, 8'd0});
    // software request with empty mask is ignored
    vq.push_back('{ 1, 1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 2'b00, 8'd0});
    // software request on ch1/ch2; ch0 untouched
    vq.push_back('{ 1, 1'b0, 1'b1, 3'b110, 3'b001, 1'b1, 2'b10, 8'd1});
    vq.push_back('{23, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'b10, 8'd1});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b10, 8'd1});
    vq.push_back('{ 7, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b10, 8'd1});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 2'b10, 8'd1});
    // external button for 5 cycles: low by edge 3, stretched until edge 7
    vq.push_back('{ 2, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 2'b10, 8'd1});
    vq.push_back('{ 1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 2, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'b01, 8'd2});
    vq.push_back('{17, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 7, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 7, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 2'b01, 8'd2});
    vq.push_back('{ 1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 2'b01, 8'd2});

    // ---------------- power-on reset ----------------
    g_resetn      = 1'b0;
    ext_reset     = 1'b0;
    sw_reset_req  = 1'b0;
    sw_reset_mask = '0;
    model_reset();
    repeat (3) @(negedge g_clk);
    chk("por_rst",   32'(rst_n_out),   32'd0);
    chk("por_busy",  32'(seq_busy),    32'd1);
    chk("por_cause", 32'(reset_cause), 32'd0);
    chk("por_count", 32'(reset_count), 32'd0);
    g_resetn = 1'b1;

    for (int v = 0; v < vq.size(); v++) begin
      for (int k = 0; k < vq[v].ncyc; k++)
        cycle(vq[v].ext, vq[v].sw && (k == 0), vq[v].mask, "tbl_model");
      chk($sformatf("vec%0d_rst", v),   32'(rst_n_out),   32'(vq[v].e_rst));
      chk($sformatf("vec%0d_busy", v),  32'(seq_busy),    32'(vq[v].e_busy));
      chk($sformatf("vec%0d_cause", v), 32'(reset_cause), 32'(vq[v].e_cause));
      chk($sformatf("vec%0d_count", v), 32'(reset_count), 32'(vq[v].e_cnt));
    end

    // ---- sw request on the edge ext_sync rises: external wins, count +1 ----
    cycle(1'b1, 1'b0, 3'b000, "t4");
    cycle(1'b1, 1'b0, 3'b000, "t4");
    cycle(1'b1, 1'b1, 3'b110, "t4");
    chk("t4_rst",   32'(rst_n_out),   32'd0);
    chk("t4_cause", 32'(reset_cause), 32'd1);
    chk("t4_count", 32'(reset_count), 32'd3);
    idle(45, "t4_tail");
    chk("t4_done", 32'(rst_n_out), 32'h7);

    // ---- external reset during RELEASE; sw during ASSERT ignored ----
    cycle(1'b1, 1'b0, 3'b000, "t5");
    idle(2, "t5");
    chk("t5_entry_rst",   32'(rst_n_out),   32'd0);
    chk("t5_entry_count", 32'(reset_count), 32'd4);
    cycle(1'b0, 1'b1, 3'b011, "t5_sw");
    chk("t5_sw_cause", 32'(reset_cause), 32'd1);
    chk("t5_sw_count", 32'(reset_count), 32'd4);
    idle(18, "t5");
    chk("t5_ch0_free", 32'(rst_n_out), 32'h1);
    cycle(1'b1, 1'b0, 3'b000, "t5");
    idle(2, "t5");
    chk("t5_reassert", 32'(rst_n_out),   32'd0);
    chk("t5_count2",   32'(reset_count), 32'd5);
    chk("t5_busy",     32'(seq_busy),    32'd1);
    idle(15, "t5");
    chk("t5_hold15", 32'(rst_n_out), 32'd0);
    idle(1, "t5");
    chk("t5_ch0", 32'(rst_n_out), 32'h1);
    idle(8, "t5");
    chk("t5_ch1", 32'(rst_n_out), 32'h3);
    idle(8, "t5");
    chk("t5_ch2",  32'(rst_n_out), 32'h7);
    chk("t5_idle", 32'(seq_busy),  32'd0);

    // ---- power-on reset in the middle of RELEASE ----
    cycle(1'b1, 1'b0, 3'b000, "t6");
    idle(24, "t6");
    chk("t6_pre", 32'(rst_n_out), 32'h1);
    #2 g_resetn = 1'b0;
    #1;
    chk("t6_rst",   32'(rst_n_out),   32'd0);
    chk("t6_busy",  32'(seq_busy),    32'd1);
    chk("t6_cause", 32'(reset_cause), 32'd0);
    chk("t6_count", 32'(reset_count), 32'd0);
    model_reset();
    ext_reset = 1'b0;
    @(negedge g_clk);
    g_resetn = 1'b1;
    idle(35, "t6_por");
    chk("t6_por_done", 32'(seq_busy), 32'd0);

    // ---- counter saturation after 256 external resets ----
    for (int r = 0; r < 256; r++) begin
      cycle(1'b1, 1'b0, 3'b000, "sat");
      idle(40, "sat");
    end
    chk("sat_count", 32'(reset_count), 32'd255);

    // ---- randomized traffic against the model ----
    begin
      int ext_left;
      bit ext_v;
      ext_left = 0;
      for (int c = 0; c < 3000; c++) begin
        if (ext_left > 0) begin
          ext_v    = 1'b1;
          ext_left = ext_left - 1;
        end else if ($urandom_range(0, 99) < 3) begin
          ext_v    = 1'b1;
          ext_left = int'($urandom_range(0, 5));
        end else begin
          ext_v = 1'b0;
        end
        cycle(ext_v, ($urandom_range(0, 9) == 0), CH'($urandom_range(0, 7)), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
